// File: rtl/hazard_pkg.sv
// hazard_pkg: register class codes, pipeline tag structs and the tag compare
// shared by the forwarding/load-use controller.
package hazard_pkg;
    localparam int TAG_RW = 8;
    localparam int TAG_CW = 8;

    typedef enum logic [TAG_CW-1:0] {
        CLS_GPR = 0,
        CLS_SP  = 1,
        CLS_T   = 2,
        CLS_IH  = 3,
        CLS_RA  = 4
    } cls_e;

    // valid already folds in dst_valid; for slot 0 it also folds in the instruction valid
    typedef struct packed {
        logic              valid;
        logic [TAG_RW-1:0] rg;
        logic [TAG_CW-1:0] cls;
        logic              is_load;
    } dst_tag_t;

    typedef struct packed {
        logic              used;
        logic [TAG_RW-1:0] rg;
        logic [TAG_CW-1:0] cls;
    } src_tag_t;

    function automatic logic tag_match(input src_tag_t s, input dst_tag_t d);
        return s.used && d.valid && (s.cls == d.cls) &&
               (s.cls != TAG_CW'(CLS_GPR) || s.rg == d.rg);
    endfunction
endpackage

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// fwd_match: one EX source against the slot 1..DEPTH destination tags;
// the youngest (lowest numbered) matching slot wins.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SELW  = 2
) (
    input  src_tag_t         i_src,
    input  dst_tag_t         i_slots [1:DEPTH],
    output logic [SELW-1:0]  o_sel
);
    always_comb begin
        o_sel = '0;
        for (int k = DEPTH; k >= 1; k--)
            if (tag_match(i_src, i_slots[k])) o_sel = SELW'(k);
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: shadow tag pipeline producing EX bypass selects and the ID load-use stall.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int CLS_W    = 3,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    localparam int SELW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_en,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [NSRC*REG_AW-1:0] id_src_reg,
    input  logic [NSRC*CLS_W-1:0]  id_src_cls,
    input  logic                   id_dst_valid,
    input  logic [REG_AW-1:0]      id_dst_reg,
    input  logic [CLS_W-1:0]       id_dst_cls,
    input  logic                   id_is_load,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   load_use_stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]            stall_cycles,
    output logic [15:0]            fwd_events
`endif
);
    dst_tag_t         r_s0;
    dst_tag_t         r_slot [1:DEPTH];
    src_tag_t         r_src [NSRC];
    src_tag_t         w_id_src [NSRC];
    dst_tag_t         w_id_dst;
    logic [SELW-1:0]  w_sel [NSRC];
    logic             w_hit;
    logic             w_cap;

    assign w_id_dst = '{valid: id_valid && id_dst_valid, rg: TAG_RW'(id_dst_reg),
                        cls: TAG_CW'(id_dst_cls), is_load: id_is_load};

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            assign w_id_src[i] = '{used: id_src_used[i],
                                   rg: TAG_RW'(id_src_reg[i*REG_AW +: REG_AW]),
                                   cls: TAG_CW'(id_src_cls[i*CLS_W +: CLS_W])};
            fwd_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match (
                .i_src   (r_src[i]),
                .i_slots (r_slot),
                .o_sel   (w_sel[i])
            );
            assign fwd_sel[i*SELW +: SELW] = w_sel[i];
            // a selected slot still short of LOAD_LAT must never hold a load
            assert property (@(posedge clk) disable iff (!rst_n)
                !(w_sel[i] != '0 && 32'(w_sel[i]) < LOAD_LAT && r_slot[w_sel[i]].is_load));
        end
    endgenerate

    // loads in slots 0..LOAD_LAT-2 cannot yet supply data to the ID instruction
    always_comb begin
        w_hit = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (LOAD_LAT >= 2 && r_s0.is_load && tag_match(w_id_src[s], r_s0)) w_hit = 1'b1;
            for (int j = 1; j <= LOAD_LAT - 2; j++)
                if (r_slot[j].is_load && tag_match(w_id_src[s], r_slot[j])) w_hit = 1'b1;
        end
    end

    assign load_use_stall = w_hit && id_valid && !flush;
    assign w_cap          = id_valid && !flush && !load_use_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0   <= '0;
            r_slot <= '{default: '0};
            r_src  <= '{default: '0};
        end else if (pipe_en) begin
            r_slot[1] <= r_s0;
            for (int k = 2; k <= DEPTH; k++) r_slot[k] <= r_slot[k-1];
            r_s0 <= w_cap ? w_id_dst : '0;
            for (int s = 0; s < NSRC; s++) r_src[s] <= w_cap ? w_id_src[s] : '0;
        end else if (flush) begin
            r_s0  <= '0;
            r_src <= '{default: '0};
        end
    end

`ifdef HAZARD_STATS_EN
    // bubbles carry no used sources, so a nonzero select implies a valid slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else if (pipe_en) begin
            if (load_use_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (|fwd_sel && fwd_events != 16'hFFFF) fwd_events <= fwd_events + 16'd1;
        end
    end
`endif
endmodule
